sample_conditioner: RTL and testbench
=====================================

# sample_conditioner

Per-sample conditioning stage between `i2s_capture_24` and `pingpong_sp_ram`. It selects one channel from the 24-bit capture output, removes DC offset with a first-order leaky integrator, and applies a power-of-two gain. It then narrows the result to `OUT_WIDTH` bits with saturation and re-issues it with a one-cycle strobe for the RAM write side.

## Interface
- `SELECT_LEFT`, 1'b1: 1 selects `left_sample_i`, 0 selects `right_sample_i`.
- `OUT_WIDTH`, 16: output sample width (8..24).
- `DC_SHIFT`, 10: DC estimator pole, `dc = acc >>> DC_SHIFT` (2..16).
- `GAIN_SHIFT`, 0: left shift applied before narrowing (0..8).
- `clk_i`  in  1  system clock (27 MHz); single clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `sample_stb_i`  in  1  one-cycle strobe, samples valid (from capture `ready_o`).
- `left_sample_i`  in  24  signed left sample.
- `right_sample_i`  in  24  signed right sample.
- `sample_o`  out  OUT_WIDTH  signed conditioned sample; held between strobes.
- `sample_ready_o`  out  1  one-cycle pulse, `sample_o` new this cycle.
- `clip_o`  out  1  high with `sample_ready_o` when saturation occurred; otherwise 0.
- `overrun_cnt_o`  out  8  count of strobes dropped while busy; saturates at 255.

## Operation
- FSM states: IDLE, SUB, SAT.
- IDLE: on `sample_stb_i`, register the selected channel into `x_q` and go to SUB.
- SUB: `y = x_q - (acc >>> DC_SHIFT)`, 25-bit signed, registered into `y_q`. Then `acc <= acc + y`, where `acc` is `25+DC_SHIFT` bits signed and saturating. Go to SAT.
- SAT: `s = (y_q <<< GAIN_SHIFT) >>> (24 - OUT_WIDTH)`, arithmetic shifts at full width with no truncation before the clamp.
  - Clamp `s` to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register the clamped value to `sample_o` and assert `sample_ready_o` for one cycle.
  - Set `clip_o` = (clamp active).
  - Go to IDLE.
- A strobe seen in SUB or SAT is dropped and increments `overrun_cnt_o` (saturating). A strobe in IDLE is always accepted, including in the cycle where `sample_ready_o` is high.
- The DC estimate converges exactly. For constant input, `acc` increases by `y ≥ 1` until `y = 0`.

## Timing
- Reset values: `sample_o`=0, `sample_ready_o`=0, `clip_o`=0, `overrun_cnt_o`=0. Internal: `acc`=0, `x_q`=0, `y_q`=0, state IDLE.
- Strobe sampled at edge N. `y_q` and `acc` update at N+1. `sample_o`, `sample_ready_o` and `clip_o` update at N+2. Latency is 2 cycles from strobe to ready; `sample_ready_o` drops at N+3.
- Minimum accepted strobe spacing is 3 cycles. I2S frame rate gives about 500 cycles.
- Reset has priority over all events. `rst_i` asserted in SUB or SAT aborts the sample: no ready pulse, and `acc` is cleared.
- `sample_o` is stable from the ready pulse until the next ready pulse.

## Configuration
- `SAMPLE_COND_DC_BLOCK_EN` defined: DC removal as described.
- Not defined:
  - `y = x_q` sign-extended to 25 bits.
  - `acc` is not implemented (reads as 0).
  - Output becomes plain gain-and-saturate. With `GAIN_SHIFT`=0, `sample_o` equals `sample[23:24-OUT_WIDTH]`.
  - Latency and handshake are unchanged.

## Test plan
- Macro off, defaults: strobe with left=24'h123456 → 2 cycles later `sample_o`=16'h1234, one-cycle `sample_ready_o`, `clip_o`=0.
- Macro on, `DC_SHIFT`=4: constant left=24'h100000 every 500 cycles → first output 16'h1000, then monotonically decreasing, reaching 16'h0000 and staying there.
- `GAIN_SHIFT`=4, macro off: 24'h7FFFFF → 16'h7FFF with `clip_o`=1; 24'h800000 → 16'h8000 with `clip_o`=1; 24'h000100 → 16'h0010 with `clip_o`=0.
- `SELECT_LEFT`=0, macro off: left=24'hAAAAAA, right=24'h0F0F0F → `sample_o`=16'h0F0F.
- Two strobes one cycle apart → a single ready pulse, `overrun_cnt_o`=1. Drive 300 such pairs → `overrun_cnt_o` holds at 255.
- `rst_i` pulsed one cycle in SAT → no ready pulse, all outputs 0. The next strobe with 24'h100000 (macro on) yields 16'h1000, proving `acc` was cleared.

Source files
------------

// File: rtl/sample_conditioner.sv
// Channel select, optional DC removal, power-of-two gain and saturating narrow to OUT_WIDTH.
// Define SAMPLE_COND_DC_BLOCK_EN to build the leaky-integrator DC blocker; otherwise acc reads as 0.
module sample_conditioner #(
  parameter bit SELECT_LEFT = 1'b1,
  parameter int OUT_WIDTH   = 16,
  parameter int DC_SHIFT    = 10,
  parameter int GAIN_SHIFT  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sample_stb_i,
  input  logic [23:0]          left_sample_i,
  input  logic [23:0]          right_sample_i,
  output logic [OUT_WIDTH-1:0] sample_o,
  output logic                 sample_ready_o,
  output logic                 clip_o,
  output logic [7:0]           overrun_cnt_o
);
  localparam int ACC_W  = 25 + DC_SHIFT;
  localparam int ACC_SW = ACC_W + 1;
  localparam int S_W    = 25 + GAIN_SHIFT;
  localparam int NARROW = 24 - OUT_WIDTH;

  typedef enum logic [1:0] {IDLE, SUB, SAT} state_t;

  state_t                  state_q;
  logic signed [23:0]      x_q;
  logic signed [24:0]      y_q, y_d;
  logic signed [25:0]      y_wide;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [S_W-1:0]   s_shl, s_full;
  logic [S_W-OUT_WIDTH:0]  s_hi;
  logic [OUT_WIDTH-1:0]    sample_q, sample_d;
  logic                    ready_q, clip_q, clip_d;
  logic [7:0]              ovr_q;

  // One extra bit so x - dc cannot wrap; clamp back to 25 bits.
  always_comb begin
    y_wide = {{2{x_q[23]}}, x_q} - 26'(acc_q >>> DC_SHIFT);
    if (y_wide[25] != y_wide[24]) begin
      y_d = y_wide[25] ? {1'b1, 24'd0} : {1'b0, {24{1'b1}}};
    end else begin
      y_d = y_wide[24:0];
    end
  end

`ifdef SAMPLE_COND_DC_BLOCK_EN
  logic signed [ACC_SW-1:0] acc_sum;
  logic signed [ACC_W-1:0]  acc_d;

  always_comb begin
    acc_sum = ACC_SW'(acc_q) + ACC_SW'(y_d);
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_d = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_d = acc_sum[ACC_W-1:0];
    end
  end
`else
  assign acc_q = '0;
`endif

  // Shifts run at full width; in range only if every bit above the output sign bit matches it.
  always_comb begin
    s_shl  = S_W'(y_q) <<< GAIN_SHIFT;
    s_full = s_shl >>> NARROW;
    s_hi   = s_full[S_W-1:OUT_WIDTH-1];
    clip_d = ~((&s_hi) | ~(|s_hi));
    if (clip_d) begin
      sample_d = s_full[S_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else begin
      sample_d = s_full[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sample_q <= '0;
      ready_q  <= 1'b0;
      clip_q   <= 1'b0;
      ovr_q    <= '0;
`ifdef SAMPLE_COND_DC_BLOCK_EN
      acc_q    <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      clip_q  <= 1'b0;
      if (sample_stb_i && state_q != IDLE && ovr_q != 8'hFF) begin
        ovr_q <= ovr_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (sample_stb_i) begin
            x_q     <= SELECT_LEFT ? left_sample_i : right_sample_i;
            state_q <= SUB;
          end
        end
        SUB: begin
          y_q     <= y_d;
`ifdef SAMPLE_COND_DC_BLOCK_EN
          acc_q   <= acc_d;
`endif
          state_q <= SAT;
        end
        SAT: begin
          sample_q <= sample_d;
          ready_q  <= 1'b1;
          clip_q   <= clip_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_o       = sample_q;
  assign sample_ready_o = ready_q;
  assign clip_o         = clip_q;
  assign overrun_cnt_o  = ovr_q;

endmodule

// File: tb/tb_sample_conditioner.sv
// Scoreboard bench for sample_conditioner: three instances (left/DC4, left/gain4/DC10, right/DC4)
// share stimulus; expected samples are queued at strobe time and popped on each ready pulse.
module tb_sample_conditioner;
`ifdef SAMPLE_COND_DC_BLOCK_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif
  localparam int DS_A = 4;
  localparam int DS_G = 10;
  localparam int DS_R = 4;

  typedef struct {
    int          rdy;
    logic [15:0] sa, sg, sr;
    logic        ca, cg, cr;
  } exp_t;

  exp_t sb_q[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [23:0] left = '0;
  logic [23:0] right = '0;

  logic [15:0] a_smp, g_smp, r_smp;
  logic        a_rdy, g_rdy, r_rdy;
  logic        a_clip, g_clip, r_clip;
  logic [7:0]  a_ovr, g_ovr, r_ovr;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_txn = 0;
  int     ovr_exp = 0;
  longint acc_a = 0, acc_g = 0, acc_r = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sample_conditioner #(.SELECT_LEFT(1'b1), .OUT_WIDTH(16), .DC_SHIFT(DS_A), .GAIN_SHIFT(0)) u_a (
    .clk_i(clk), .rst_i(rst), .sample_stb_i(stb),
    .left_sample_i(left), .right_sample_i(right),
    .sample_o(a_smp), .sample_ready_o(a_rdy), .clip_o(a_clip), .overrun_cnt_o(a_ovr)
  );

  sample_conditioner #(.SELECT_LEFT(1'b1), .OUT_WIDTH(16), .GAIN_SHIFT(4)) u_g (
    .clk_i(clk), .rst_i(rst), .sample_stb_i(stb),
    .left_sample_i(left), .right_sample_i(right),
    .sample_o(g_smp), .sample_ready_o(g_rdy), .clip_o(g_clip), .overrun_cnt_o(g_ovr)
  );

  sample_conditioner #(.SELECT_LEFT(1'b0), .OUT_WIDTH(16), .DC_SHIFT(DS_R), .GAIN_SHIFT(0)) u_r (
    .clk_i(clk), .rst_i(rst), .sample_stb_i(stb),
    .left_sample_i(left), .right_sample_i(right),
    .sample_o(r_smp), .sample_ready_o(r_rdy), .clip_o(r_clip), .overrun_cnt_o(r_ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural reference in plain integer arithmetic.
  task automatic model(input logic [23:0] xin, input int ds, input int gs,
                       inout longint acc, output logic [15:0] smp, output logic clp);
    longint x, y, s, lim;
    x = longint'($signed(xin));
    if (DC_EN) begin
      y   = x - (acc >>> ds);
      lim = longint'(1) <<< 24;
      if (y >= lim) y = lim - 1;
      else if (y < -lim) y = -lim;
      lim = longint'(1) <<< (24 + ds);
      acc = acc + y;
      if (acc >= lim) acc = lim - 1;
      else if (acc < -lim) acc = -lim;
    end else begin
      y = x;
    end
    s   = (y <<< gs) >>> 8;
    clp = (s > 32767) || (s < -32768);
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    smp = s[15:0];
  endtask

  task automatic push_expected(input logic [23:0] l, input logic [23:0] r);
    exp_t e;
    e.rdy = cyc + 3;
    model(l, DS_A, 0, acc_a, e.sa, e.ca);
    model(l, DS_G, 4, acc_g, e.sg, e.cg);
    model(r, DS_R, 0, acc_r, e.sr, e.cr);
    sb_q.push_back(e);
  endtask

  // Strobe once, then idle so consecutive calls land exactly 3 cycles apart.
  task automatic send(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    left = l; right = r; stb = 1'b1;
    push_expected(l, r);
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
  endtask

  // Accepted strobe followed immediately by one that must be dropped.
  task automatic send_pair(input logic [23:0] l);
    @(negedge clk);
    left = l; right = ~l; stb = 1'b1;
    push_expected(l, ~l);
    @(negedge clk);
    left = l ^ 24'h5A5A5A; right = l ^ 24'hA5A5A5;
    if (ovr_exp < 255) ovr_exp++;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acc_a = 0; acc_g = 0; acc_r = 0; ovr_exp = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_rdy | g_rdy | r_rdy) begin
      if (sb_q.size() == 0) begin
        check("spurious_ready", {29'd0, a_rdy, g_rdy, r_rdy}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        n_txn++;
        $display("txn %0d cyc %0d: a=%h/%0b g=%h/%0b r=%h/%0b", n_txn, cyc,
                 a_smp, a_clip, g_smp, g_clip, r_smp, r_clip);
        check("latency",   cyc, e.rdy);
        check("ready_all", {a_rdy, g_rdy, r_rdy}, 3'b111);
        check("a_sample",  a_smp, e.sa);
        check("a_clip",    a_clip, e.ca);
        check("g_sample",  g_smp, e.sg);
        check("g_clip",    g_clip, e.cg);
        check("r_sample",  r_smp, e.sr);
        check("r_clip",    r_clip, e.cr);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_sample", a_smp, 16'h0000);
    check("rst_ready",  a_rdy, 1'b0);
    check("rst_clip",   a_clip, 1'b0);
    check("rst_ovr",    a_ovr, 8'd0);

    send(24'h123456, 24'h0F0F0F);
    @(negedge clk);
    check("basic_a",    a_smp, 16'h1234);
    check("basic_clip", a_clip, 1'b0);
    check("sel_right",  r_smp, 16'h0F0F);
    @(negedge clk);
    check("ready_drop", a_rdy, 1'b0);
    check("hold",       a_smp, 16'h1234);

    do_reset();
    send(24'h7FFFFF, 24'h000000);
    @(negedge clk);
    check("gain_pos",      g_smp, 16'h7FFF);
    check("gain_pos_clip", g_clip, 1'b1);
    @(negedge clk);
    check("clip_drop",     g_clip, 1'b0);
    do_reset();
    send(24'h800000, 24'h000000);
    @(negedge clk);
    check("gain_neg",      g_smp, 16'h8000);
    check("gain_neg_clip", g_clip, 1'b1);
    do_reset();
    send(24'h000100, 24'h000000);
    @(negedge clk);
    check("gain_small",      g_smp, 16'h0010);
    check("gain_small_clip", g_clip, 1'b0);

    do_reset();
    send(24'hAAAAAA, 24'h0F0F0F);
    @(negedge clk);
    check("sel_right_aa", r_smp, 16'h0F0F);
    repeat (5) send(24'($urandom), 24'($urandom));
    @(negedge clk);
    left = 24'h100000; right = 24'h100000; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_a = 0; acc_g = 0; acc_r = 0; ovr_exp = 0;
    check("abort_sample", a_smp, 16'h0000);
    check("abort_ready",  a_rdy, 1'b0);
    check("abort_clip",   a_clip, 1'b0);
    check("abort_ovr",    a_ovr, 8'd0);
    @(negedge clk);
    check("abort_no_ready", a_rdy, 1'b0);
    send(24'h100000, 24'h100000);
    @(negedge clk);
    check("acc_cleared", a_smp, 16'h1000);

    repeat (40) send(24'($urandom), 24'($urandom));

    do_reset();
    send(24'h100000, 24'h100000);
    @(negedge clk);
    check("dc_first", a_smp, 16'h1000);
    repeat (249) send(24'h100000, 24'h100000);
    @(negedge clk);
    check("dc_final", a_smp, DC_EN ? 16'h0000 : 16'h1000);

    do_reset();
    send_pair(24'h010000);
    repeat (3) @(negedge clk);
    check("ovr_one", a_ovr, ovr_exp);
    repeat (299) send_pair(24'($urandom));
    repeat (4) @(negedge clk);
    check("ovr_sat_a", a_ovr, ovr_exp);
    check("ovr_sat_g", g_ovr, ovr_exp);
    check("ovr_sat_r", r_ovr, ovr_exp);

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
